servo_instr_tx: RTL and testbench

- Transmitter end of the bit-serial servo instruction link (command/confirm/data_ready).
- Takes a parallel WIDTH-bit servo instruction: bits [9:8] are the opcode (01 turntable, 10 extend track, 11 retract track); bits [7:0] are the position.
- Sends it MSB-first to a receiving FPGA, one bit per four-phase confirm/data_ready handshake.
- Used as the MBED-replacement master in self-test and dual-board builds.

---
 rtl/servo_instr_tx.sv | 197 +++++++++++++++++++
 tb/tb_servo_instr_tx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_instr_tx.sv
// Transmitter end of the bit-serial servo instruction link: shifts a WIDTH-bit
// instruction out MSB-first, one bit per four-phase confirm/data_ready handshake.
module servo_instr_tx #(
    parameter int WIDTH          = 10,
    parameter int SETUP_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] instr,
    input  logic             data_ready,
    output logic             command,
    output logic             confirm,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [3:0]       bit_index
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    // With the timeout disabled the counter simply parks at all-ones.
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_EN ? TMO_W'(TIMEOUT_CYCLES) : {TMO_W{1'b1}};
    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES);
    localparam logic [3:0] TOP_INDEX  = 4'(WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_WAIT_REL = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [1:0]       sync_r;
    logic             ack_s;
    logic [WIDTH-1:0] shreg_r, shreg_nxt_s;
    logic [3:0]       bit_index_r, bit_index_nxt_s;
    logic [7:0]       setup_cnt_r, setup_cnt_nxt_s;
    logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_nxt_s, tmo_inc_s;
    logic             confirm_r, confirm_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;
    logic             error_r, error_nxt_s;
    logic             tmo_hit_s, abort_s, setup_end_s;

    assign ack_s       = sync_r[1];
    assign tmo_hit_s   = TMO_EN && (tmo_cnt_r == TMO_LIM);
    assign tmo_inc_s   = (tmo_cnt_r == TMO_LIM) ? tmo_cnt_r : tmo_cnt_r + TMO_W'(1);
    assign abort_s     = tmo_hit_s && ((state_r == ST_SETUP) || (state_r == ST_WAIT_ACK) ||
                                       (state_r == ST_WAIT_REL));
    assign setup_end_s = !ack_s && (setup_cnt_r <= 8'd1);

    // Two-flop synchronizer for the receiver's asynchronous acknowledge.
    always_ff @(posedge clk) begin
        if (reset) sync_r <= 2'b00;
        else       sync_r <= {sync_r[0], data_ready};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_nxt_s;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:     if (start) state_nxt_s = ST_SETUP; else state_nxt_s = ST_IDLE;
            ST_SETUP:    if (abort_s) state_nxt_s = ST_IDLE;
                         else if (setup_end_s) state_nxt_s = ST_WAIT_ACK;
                         else state_nxt_s = ST_SETUP;
            ST_WAIT_ACK: if (abort_s) state_nxt_s = ST_IDLE;
                         else if (ack_s) state_nxt_s = ST_WAIT_REL;
                         else state_nxt_s = ST_WAIT_ACK;
            ST_WAIT_REL: if (abort_s) state_nxt_s = ST_IDLE;
                         else if (!ack_s) state_nxt_s = (bit_index_r == 4'd0) ? ST_DONE : ST_SETUP;
                         else state_nxt_s = ST_WAIT_REL;
            ST_DONE:     state_nxt_s = ST_IDLE;
            default:     state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath; command is the shreg MSB,
    // so shifting zeros in leaves command low once the last bit has gone.
    always_comb begin
        shreg_nxt_s     = shreg_r;
        bit_index_nxt_s = bit_index_r;
        setup_cnt_nxt_s = setup_cnt_r;
        tmo_cnt_nxt_s   = tmo_cnt_r;
        confirm_nxt_s   = confirm_r;
        busy_nxt_s      = busy_r;
        done_nxt_s      = 1'b0;
        error_nxt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    shreg_nxt_s     = instr;
                    bit_index_nxt_s = TOP_INDEX;
                    setup_cnt_nxt_s = SETUP_LOAD;
                    tmo_cnt_nxt_s   = {TMO_W{1'b0}};
                    busy_nxt_s      = 1'b1;
                    confirm_nxt_s   = 1'b0;
                end else begin
                    shreg_nxt_s     = {WIDTH{1'b0}};
                    bit_index_nxt_s = 4'd0;
                    busy_nxt_s      = 1'b0;
                    confirm_nxt_s   = 1'b0;
                end
            end
            ST_SETUP, ST_WAIT_ACK, ST_WAIT_REL: begin
                if (abort_s) begin
                    shreg_nxt_s     = {WIDTH{1'b0}};
                    bit_index_nxt_s = 4'd0;
                    tmo_cnt_nxt_s   = {TMO_W{1'b0}};
                    confirm_nxt_s   = 1'b0;
                    busy_nxt_s      = 1'b0;
                    error_nxt_s     = 1'b1;
                end else if (state_r == ST_SETUP) begin
                    if (ack_s) begin
                        tmo_cnt_nxt_s = tmo_inc_s;
                    end else if (setup_end_s) begin
                        setup_cnt_nxt_s = 8'd0;
                        tmo_cnt_nxt_s   = {TMO_W{1'b0}};
                        confirm_nxt_s   = 1'b1;
                    end else begin
                        setup_cnt_nxt_s = setup_cnt_r - 8'd1;
                    end
                end else if (state_r == ST_WAIT_ACK) begin
                    if (ack_s) begin
                        confirm_nxt_s = 1'b0;
                        tmo_cnt_nxt_s = {TMO_W{1'b0}};
                    end else begin
                        tmo_cnt_nxt_s = tmo_inc_s;
                    end
                end else begin
                    if (!ack_s) begin
                        shreg_nxt_s   = {shreg_r[WIDTH-2:0], 1'b0};
                        tmo_cnt_nxt_s = {TMO_W{1'b0}};
                        if (bit_index_r == 4'd0) begin
                            busy_nxt_s = 1'b0;
                            done_nxt_s = 1'b1;
                        end else begin
                            bit_index_nxt_s = bit_index_r - 4'd1;
                            setup_cnt_nxt_s = SETUP_LOAD;
                        end
                    end else begin
                        tmo_cnt_nxt_s = tmo_inc_s;
                    end
                end
            end
            ST_DONE: begin
                busy_nxt_s = 1'b0;
            end
            default: begin
                shreg_nxt_s     = {WIDTH{1'b0}};
                bit_index_nxt_s = 4'd0;
                confirm_nxt_s   = 1'b0;
                busy_nxt_s      = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_r     <= {WIDTH{1'b0}};
            bit_index_r <= 4'd0;
            setup_cnt_r <= 8'd0;
            tmo_cnt_r   <= {TMO_W{1'b0}};
            confirm_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            shreg_r     <= shreg_nxt_s;
            bit_index_r <= bit_index_nxt_s;
            setup_cnt_r <= setup_cnt_nxt_s;
            tmo_cnt_r   <= tmo_cnt_nxt_s;
            confirm_r   <= confirm_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            error_r     <= error_nxt_s;
        end
    end

    assign command   = shreg_r[WIDTH-1];
    assign confirm   = confirm_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign error     = error_r;
    assign bit_index = bit_index_r;

endmodule

// File: tb/tb_servo_instr_tx.sv
// Scoreboard bench for servo_instr_tx: requests push expected outcomes, a monitor
// checks each handshake bit, its timing and the done/error/reset outcome.
module tb_servo_instr_tx;
    localparam int WIDTH  = 10;
    localparam int SETUP  = 4;
    localparam int TMO    = 20;
    localparam int K_DONE = 0;
    localparam int K_ERR  = 1;
    localparam int K_RST  = 2;

    typedef struct {
        int               kind;
        logic [WIDTH-1:0] word;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] instr;
    logic             data_ready;
    logic             command, confirm, busy, done, error;
    logic [3:0]       bit_index;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   start_ref = 0;
    int   rel_ref = 0;
    int   dr_rise = 0;
    int   rx_lat = 3;
    int   stim_tmo = 0;
    bit   rx_noack = 1'b0;
    bit   rx_hold = 1'b0;
    bit   finish_req = 1'b0;
    logic rst_q = 1'b0;
    exp_t exp_q[$];

    servo_instr_tx #(.WIDTH(WIDTH), .SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr), .data_ready(data_ready),
        .command(command), .confirm(confirm), .busy(busy), .done(done), .error(error),
        .bit_index(bit_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] w, input int kind);
        exp_t e;
        e.kind = kind;
        e.word = w;
        exp_q.push_back(e);
        instr     = w;
        start     = 1'b1;
        start_ref = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || error) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!(done || error)) stim_tmo++;
    endtask

    task automatic wait_bit(input int idx);
        int n = 0;
        while (!(confirm && (int'(bit_index) == idx)) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!confirm) stim_tmo++;
    endtask

    // Stimulus
    initial begin
        reset = 1'b1;
        start = 1'b0;
        instr = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        send(10'b1010000000, K_DONE);
        wait_end();
        repeat (3) @(negedge clk);
        send(10'h155, K_DONE);
        wait_bit(5);
        instr = 10'h3FF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end();
        repeat (20) @(negedge clk);
        rx_noack = 1'b1;
        send(WIDTH'($urandom), K_ERR);
        wait_end();
        @(negedge clk);
        rx_noack = 1'b0;
        repeat (5) @(negedge clk);
        rx_hold = 1'b1;
        repeat (5) @(negedge clk);
        send(WIDTH'($urandom), K_DONE);
        repeat (9) @(negedge clk);
        rx_hold = 1'b0;
        wait_end();
        repeat (3) @(negedge clk);
        send(10'h3C5, K_RST);
        wait_bit(3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        send(10'b0100010000, K_DONE);
        wait_end();
        @(negedge clk);
        send(WIDTH'($urandom), K_DONE);
        wait_end();
        for (int i = 0; i < 6; i++) begin
            rx_lat = $urandom_range(1, 5);
            repeat ($urandom_range(1, 4)) @(negedge clk);
            send(WIDTH'($urandom), K_DONE);
            wait_end();
        end
        repeat (10) @(negedge clk);
        finish_req = 1'b1;
    end

    // Receiver: acks each confirm after rx_lat cycles, releases rx_lat cycles after confirm drops
    initial begin
        bit held = 1'b0;
        int g;
        data_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_hold) begin
                data_ready = 1'b1;
                held       = 1'b1;
            end else if (held) begin
                data_ready = 1'b0;
                held       = 1'b0;
                rel_ref    = cyc + 2;
            end else if (confirm && !rx_noack) begin
                repeat (rx_lat) @(negedge clk);
                data_ready = 1'b1;
                dr_rise    = cyc;
                g = 0;
                while (confirm && g < 200) begin
                    @(negedge clk);
                    g++;
                end
                repeat (rx_lat) @(negedge clk);
                data_ready = 1'b0;
                rel_ref    = cyc + 3;
            end
        end
    end

    // Monitor and scoreboard
    initial begin
        int               nbits = 0;
        int               rise_cyc = 0;
        logic [WIDTH-1:0] acc = '0;
        logic             conf_p = 1'b0, cmd_p = 1'b0, done_p = 1'b0, err_p = 1'b0;
        logic             rst_p = 1'b0;
        exp_t             e;
        forever begin
            @(negedge clk);
            if (finish_req) begin
                chk("queue_drained", exp_q.size(), 0);
                chk("stimulus_waits", stim_tmo, 0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
            if (cyc > 20000) begin
                n_fail++;
                $display("FAIL watchdog: cycle %0d, required below 20000", cyc);
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
            if (rst_q) begin
                chk("reset_outputs", int'({command, confirm, busy, done, error, bit_index}), 0);
                if (!rst_p && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("reset_kind", e.kind, K_RST);
                end
                nbits = 0;
            end else begin
                if (confirm && !conf_p) begin
                    chk("pending_request_at_bit", int'(exp_q.size() > 0), 1);
                    chk("bit_slot", int'(nbits < WIDTH), 1);
                    if (exp_q.size() > 0 && nbits < WIDTH) begin
                        e = exp_q[0];
                        chk("bit_value", int'(command), int'(e.word[WIDTH-1-nbits]));
                        chk("bit_index", int'(bit_index), WIDTH - 1 - nbits);
                        chk("busy_in_bit", int'(busy), 1);
                        chk("setup_time", cyc, ((start_ref > rel_ref) ? start_ref : rel_ref) + SETUP);
                        acc = {acc[WIDTH-2:0], command};
                        nbits++;
                    end
                    rise_cyc = cyc;
                end
                if (!confirm && conf_p && !error)
                    chk("release_time", cyc - dr_rise, 3);
                if (!rst_p && (confirm != conf_p) && !error)
                    chk("command_stable_on_confirm_edge", int'(command), int'(cmd_p));
                if (done) begin
                    chk("done_pulse_width", int'(done_p), 0);
                    chk("error_with_done", int'(error), 0);
                    chk("busy_in_done", int'(busy), 0);
                    chk("command_in_done", int'(command), 0);
                    chk("bit_index_in_done", int'(bit_index), 0);
                    chk("pending_request_at_done", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("done_kind", e.kind, K_DONE);
                        chk("bits_sent", nbits, WIDTH);
                        chk("word_sent", int'(acc), int'(e.word));
                    end
                    nbits = 0;
                end
                if (error) begin
                    chk("error_pulse_width", int'(err_p), 0);
                    chk("confirm_after_abort", int'(confirm), 0);
                    chk("busy_after_abort", int'(busy), 0);
                    chk("command_after_abort", int'(command), 0);
                    chk("bit_index_after_abort", int'(bit_index), 0);
                    chk("pending_request_at_error", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("error_kind", e.kind, K_ERR);
                        chk("timeout_latency", cyc - rise_cyc, TMO + 1);
                    end
                    nbits = 0;
                end
            end
            conf_p = confirm;
            cmd_p  = command;
            done_p = done;
            err_p  = error;
            rst_p  = rst_q;
        end
    end

endmodule
